// File: rtl/calculation_unit_fraction_normalizer.sv
// Two-stage normalizer: S1 captures the adder result and locates its leading one,
// S2 shifts it into a 1.23 mantissa with guard/round/sticky and an adjusted exponent.
module calculation_unit_fraction_normalizer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [48:0] in_fraction,
    input  logic [9:0]  in_exponent,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_fraction,
    output logic        out_guard,
    output logic        out_round,
    output logic        out_sticky,
    output logic [9:0]  out_exponent,
    output logic        out_zero
);

    logic        s1_valid_q;
    logic [48:0] s1_frac_q;
    logic [9:0]  s1_exp_q;
    logic [5:0]  s1_p_q;
    logic        s1_zero_q;

    logic        s2_valid_q;
    logic [23:0] s2_mant_q;
    logic        s2_guard_q;
    logic        s2_round_q;
    logic        s2_sticky_q;
    logic [9:0]  s2_exp_q;
    logic        s2_zero_q;

    logic        s2_adv;
    logic        in_xfer;
    logic        s2_load;

    logic [5:0]  p_d;
    logic        zero_d;

    logic [5:0]  lz;
    logic [47:0] shifted;
    logic [23:0] mant_d;
    logic        guard_d;
    logic        round_d;
    logic        sticky_d;
    logic [9:0]  exp_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_adv;

    // Leading-one position; the last hit in an ascending scan is the MSB.
    always_comb begin
        p_d = 6'd0;
        for (int i = 0; i < 49; i++) begin
            if (in_fraction[i]) begin
                p_d = i[5:0];
            end
        end
        zero_d = (in_fraction == 49'd0);
    end

    always_comb begin
        lz       = 6'd47 - s1_p_q;
        shifted  = s1_frac_q[47:0] << lz;
        mant_d   = shifted[47:24];
        guard_d  = shifted[23];
        round_d  = shifted[22];
        sticky_d = |shifted[21:0];
        exp_d    = s1_exp_q - {4'd0, lz};
        if (s1_p_q == 6'd48) begin
            mant_d   = s1_frac_q[48:25];
            guard_d  = s1_frac_q[24];
            round_d  = s1_frac_q[23];
            sticky_d = |s1_frac_q[22:0];
            exp_d    = s1_exp_q + 10'd1;
        end
        if (s1_zero_q) begin
            mant_d   = 24'd0;
            guard_d  = 1'b0;
            round_d  = 1'b0;
            sticky_d = 1'b0;
            exp_d    = 10'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_exp_q   <= '0;
            s1_p_q     <= '0;
            s1_zero_q  <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid_q <= 1'b1;
                s1_frac_q  <= in_fraction;
                s1_exp_q   <= in_exponent;
                s1_p_q     <= p_d;
                s1_zero_q  <= zero_d;
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_mant_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_round_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_exp_q    <= '0;
            s2_zero_q   <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_q  <= 1'b1;
                s2_mant_q   <= mant_d;
                s2_guard_q  <= guard_d;
                s2_round_q  <= round_d;
                s2_sticky_q <= sticky_d;
                s2_exp_q    <= exp_d;
                s2_zero_q   <= s1_zero_q;
            end else if (s2_adv) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_fraction = s2_mant_q;
    assign out_guard    = s2_guard_q;
    assign out_round    = s2_round_q;
    assign out_sticky   = s2_sticky_q;
    assign out_exponent = s2_exp_q;
    assign out_zero     = s2_zero_q;

endmodule

// File: tb/tb_calculation_unit_fraction_normalizer.sv
// Bench for the fraction normalizer: directed vector table, random stream against
// a reference model, and hand sequences for backpressure, bubbles and mid-stream reset.
module tb_calculation_unit_fraction_normalizer;

    typedef struct packed {
        logic [48:0] frac;
        logic [9:0]  exp;
        logic [23:0] m;
        logic        g;
        logic        r;
        logic        s;
        logic [9:0]  oe;
        logic        z;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] in_fraction;
    logic [9:0]  in_exponent;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_fraction;
    logic        out_guard;
    logic        out_round;
    logic        out_sticky;
    logic [9:0]  out_exponent;
    logic        out_zero;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t cur_exp;
    vec_t exp_q[$];
    vec_t tbl[12];

    calculation_unit_fraction_normalizer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fraction (in_fraction),
        .in_exponent (in_exponent),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fraction(out_fraction),
        .out_guard   (out_guard),
        .out_round   (out_round),
        .out_sticky  (out_sticky),
        .out_exponent(out_exponent),
        .out_zero    (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: align the leading one to bit 63 of a 64-bit word, then slice.
    function automatic vec_t model(input logic [48:0] f, input logic [9:0] e);
        vec_t v;
        logic [63:0] x;
        int k;
        v = '0;
        v.frac = f;
        v.exp  = e;
        if (f == 49'd0) begin
            v.z = 1'b1;
            return v;
        end
        k = 48;
        while (f[k] == 1'b0) k--;
        x = {15'd0, f} << (63 - k);
        v.m  = x[63:40];
        v.g  = x[39];
        v.r  = x[38];
        v.s  = |x[37:0];
        v.oe = e + 10'(k) - 10'd47;
        return v;
    endfunction

    function automatic vec_t mk(input logic [48:0] f, input logic [9:0] e, input logic [23:0] m,
                                input logic g, input logic r, input logic s,
                                input logic [9:0] oe, input logic z);
        vec_t v;
        v.frac = f; v.exp = e; v.m = m; v.g = g; v.r = r; v.s = s; v.oe = oe; v.z = z;
        return v;
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer (output is always older).
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got m=%06h e=%03h, expected no output",
                             out_fraction, out_exponent);
                end else begin
                    vec_t v;
                    v = exp_q.pop_front();
                    if ({out_fraction, out_guard, out_round, out_sticky, out_exponent, out_zero}
                        !== {v.m, v.g, v.r, v.s, v.oe, v.z}) begin
                        n_fail++;
                        $display("FAIL output f=%013h: got m=%06h grs=%b%b%b e=%03h z=%b, expected m=%06h grs=%b%b%b e=%03h z=%b",
                                 v.frac, out_fraction, out_guard, out_round, out_sticky, out_exponent, out_zero,
                                 v.m, v.g, v.r, v.s, v.oe, v.z);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic send(input vec_t v, input bit random_bp);
        bit acc;
        int n;
        cur_exp     = v;
        in_fraction = v.frac;
        in_exponent = v.exp;
        in_valid    = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            if (random_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = mk(49'h0_8000_0000_0000, 10'd127, 24'h800000, 0, 0, 0, 10'd127, 0);
        tbl[1]  = mk(49'h1_0000_0000_0001, 10'd127, 24'h800000, 0, 0, 1, 10'd128, 0);
        tbl[2]  = mk(49'h0_0000_0100_0000, 10'd127, 24'h800000, 0, 0, 0, 10'd104, 0);
        tbl[3]  = mk(49'h0_0000_0100_0000, 10'd5,   24'h800000, 0, 0, 0, 10'h3EE, 0);
        tbl[4]  = mk(49'h0,                10'd77,  24'h000000, 0, 0, 0, 10'd0,   1);
        tbl[5]  = mk(49'h0_0000_0000_0007, 10'd127, 24'hE00000, 0, 0, 0, 10'd82,  0);
        tbl[6]  = mk(49'h1_FFFF_FFFF_FFFF, 10'd0,   24'hFFFFFF, 1, 1, 1, 10'd1,   0);
        tbl[7]  = mk(49'h0_C000_0080_0000, 10'd10,  24'hC00000, 1, 0, 0, 10'd10,  0);
        tbl[8]  = mk(49'h0_0000_0000_0001, 10'd0,   24'h800000, 0, 0, 0, 10'h3D1, 0);
        tbl[9]  = mk(49'h1_0000_0180_0000, 10'h3FF, 24'h800000, 1, 1, 0, 10'd0,   0);
        tbl[10] = mk(49'h0_8000_0000_0001, 10'd1,   24'h800000, 0, 0, 1, 10'd1,   0);
        tbl[11] = mk(49'h0_0000_0000_0003, 10'd50,  24'hC00000, 0, 0, 0, 10'd4,   0);

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_fraction = '0;
        in_exponent = '0;
        out_ready   = 1'b1;
        cur_exp     = '0;
        #23;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", {out_fraction, out_guard, out_round, out_sticky, out_exponent, out_zero}, 64'd0);
        reset = 1'b0;
        tick();
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed table, back-to-back at full throughput.
        for (int i = 0; i < 12; i++) send(tbl[i], 1'b0);
        drain();

        // Latency and bubble: P, one idle cycle, Q.
        send(model(49'h0_1234_5678_9ABC, 10'd200), 1'b0);
        chk("latency_edge_n", 64'(out_valid), 64'd0);
        tick();
        chk("latency_edge_n1", 64'(out_valid), 64'd1);
        send(model(49'h0_0000_00AB_CDEF, 10'd300), 1'b0);
        chk("bubble_low", 64'(out_valid), 64'd0);
        tick();
        chk("bubble_resume", 64'(out_valid), 64'd1);
        drain();

        // Backpressure: A and B fill the pipe, C waits.
        out_ready = 1'b0;
        send(model(49'h0_8000_0000_00AA, 10'd11), 1'b0);
        send(model(49'h0_0F00_0000_0000, 10'd22), 1'b0);
        cur_exp     = model(49'h0_0000_0003_0000, 10'd33);
        in_fraction = cur_exp.frac;
        in_exponent = cur_exp.exp;
        in_valid    = 1'b1;
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold", {out_valid, in_ready, out_fraction, out_exponent}, {1'b1, 1'b0, 24'h800000, 10'd11});
        end
        out_ready = 1'b1;
        #1;
        chk("simul_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("stream_b_valid", 64'(out_valid), 64'd1);
        tick();
        chk("stream_c_valid", 64'(out_valid), 64'd1);
        tick();
        chk("stream_end", 64'(out_valid), 64'd0);
        drain();

        // Mid-stream reset with two items in flight.
        out_ready = 1'b0;
        send(model(49'h0_4000_0000_0000, 10'd90), 1'b0);
        send(model(49'h0_0000_7000_0000, 10'd91), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_data", {out_fraction, out_exponent, out_zero}, 64'd0);
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_empty", 64'(out_valid), 64'd0);
        end
        send(model(49'h0_0000_0000_1000, 10'd400), 1'b0);
        chk("post_reset_lat0", 64'(out_valid), 64'd0);
        tick();
        chk("post_reset_lat1", 64'(out_valid), 64'd1);
        drain();

        // Random stream with random backpressure and input gaps.
        for (int i = 0; i < 300; i++) begin
            logic [48:0] f;
            logic [9:0]  e;
            f = {$urandom(), $urandom()};
            f = f >> $urandom_range(0, 49);
            e = 10'($urandom());
            send(model(f, e), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                out_ready = ($urandom_range(0, 1) != 0);
                tick();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calculation_unit_fraction_normalizer.md
# calculation_unit_fraction_normalizer

Two-stage pipelined normalizer that takes the 49-bit `[xx.xxx…]` fraction from the calculation unit's fraction adder/subtractor and turns it into a normalized 1.23 mantissa. It also produces guard, round and sticky bits, an adjusted exponent and a zero flag. It sits between the fraction adder/subtractor and the rounding stage, and uses a valid/ready handshake on both sides.

## Interface
- No parameters; all widths are fixed.
- `clk` input 1 — single clock; all state changes on its rising edge.
- `reset` input 1 — asynchronous, active-high; clears all pipeline state.
- `in_valid` input 1 — upstream presents a result.
- `in_ready` output 1 — normalizer accepts `in_*` this cycle.
- `in_fraction` input 49 — unsigned, 2 integer bits and 47 fractional bits.
- `in_exponent` input 10 — two's-complement exponent associated with `in_fraction`.
- `out_valid` output 1 — normalized result available.
- `out_ready` input 1 — downstream accepts result this cycle.
- `out_fraction` output 24 — normalized mantissa, 1.23 format; bit 23 is set unless `out_zero`.
- `out_guard`, `out_round`, `out_sticky` output 1 each — first, second, and OR-of-remaining bits below the mantissa LSB.
- `out_exponent` output 10 — adjusted exponent, two's complement, modulo 2^10.
- `out_zero` output 1 — input fraction was exactly zero.

## Operation
- **Stage 1 (register S1)**
  - Capture fraction and exponent.
  - Compute `p` = index of the most significant set bit of `in_fraction` (0..48).
  - Compute `zero` = (`in_fraction` == 0).
- **Stage 2 (register S2): normalize from S1 contents.**
  - `p` = 48: shift right by 1.
    - Mantissa = `f[48:25]`, guard = `f[24]`, round = `f[23]`, sticky = OR `f[22:0]`.
    - Exponent = e + 1.
  - `p` ≤ 47: let `lz` = 47 − p. Shift `f` left by `lz` into `g`.
    - Mantissa = `g[47:24]`, guard = `g[23]`, round = `g[22]`, sticky = OR `g[21:0]`.
    - Exponent = e − `lz`.
  - `zero`: mantissa, guard, round, sticky and exponent are all 0; `out_zero` = 1.
- Exponent arithmetic is 10-bit wrap-around with no saturation. Under/overflow detection belongs to the rounding stage.
- **Handshake**
  - A transfer occurs when valid && ready on the same edge.
  - `in_valid` and data must be held stable until accepted.
- **Stall logic**
  - `s2_adv` = !`s2_valid` || `out_ready`.
  - `in_ready` = !`s1_valid` || `s2_adv`. This is a combinational path from `out_ready`.
  - S1 loads on input transfer. If S1 is not reloaded but S2 advances, `s1_valid` clears.
  - S2 loads from S1 when `s1_valid` && `s2_adv`. If `s2_adv` and S1 is empty, `s2_valid` clears.
  - `out_*` data equal the S2 registers directly, with no combinational path from inputs.
- Order is strictly preserved: no drops, no duplicates.

## Timing
- **Reset (asynchronous, any cycle)**
  - `s1_valid` = `s2_valid` = 0, so `out_valid` = 0.
  - All `out_*` data = 0.
  - `in_ready` = 1 the first cycle after reset deasserts.
  - In-flight items are discarded.
- **Latency:** data accepted at edge N appears with `out_valid` = 1 after edge N+1, if `out_ready` was not blocking.
- **Throughput:** one result per cycle with `out_ready` held high.
- **Full:** both stages valid and `out_ready` = 0 give `in_ready` = 0. Both registers hold their values, and `out_*` is stable while stalled.
- **Simultaneous output and input transfer when full:** S2 takes S1, S1 takes the input, and `in_ready` stays 1.
- **Bubble:** with `out_ready` = 1, `in_valid` low for one cycle yields exactly one `out_valid`-low cycle, two cycles later.

## Test plan
- **Normal input.** `in_fraction` = 49'h0_8000_0000_0000 (bit 47), exponent 127 -> `out_fraction` 24'h800000, G/R/S = 0/0/0, exponent 127, `out_zero` 0, `out_valid` two edges after acceptance.
- **Carry case.** `in_fraction` = 49'h1_0000_0000_0001, exponent 127 -> `out_fraction` 24'h800000, guard 0, round 0, sticky 1, exponent 128.
- **Large left shift with wrap.**
  - `in_fraction` = 49'h0_0000_0100_0000 (bit 24), exponent 127 -> `out_fraction` 24'h800000, exponent 104.
  - Same fraction with exponent 5 -> `out_exponent` 10'h3EE (−18).
- **Zero and low-bit inputs.**
  - `in_fraction` = 0, exponent 77 -> `out_zero` 1, all other outputs 0.
  - `in_fraction` = 49'h0_0000_0000_0007 -> `out_fraction` 24'hE00000, exponent 127 − 45 = 82.
- **Backpressure.** Stream A, B, C with `out_ready` = 0 for 4 cycles -> `in_ready` falls after A and B are held, C waits. After `out_ready` rises, A, B, C emerge in order on consecutive cycles.
- **Mid-stream reset.** Assert `reset` asynchronously with 2 items in flight -> `out_valid` drops immediately, no item emerges afterwards, and a new item after reset appears with 2-cycle latency.
